// File: rtl/ingress_mac_filter.sv
// Ingress MAC filter. Classifies the header beat of each AXI4-Stream packet against a
// per-port MAC table, then forwards or discards the whole packet. Saturating per-port
// pass/drop counters plus a counter for packets with an ambiguous MAC source.
//
// Handshake: a beat moves on a stream interface only in a cycle where both TVALID and
// TREADY are high. TVALID never depends on TREADY of the same interface. Beats are never
// created, duplicated or reordered; a discarded packet is consumed without any M_AXIS_TVALID.
module ingress_mac_filter #(
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = 16,
  parameter int NUM_PORTS            = 4,
  parameter int FIFO_DEPTH_BITS      = 4,
  parameter int DROP_EN              = 1,
  parameter int MCAST_EN             = 0
) (
  input  logic                                AXI_ACLK,
  input  logic                                AXI_RESETN,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
  input  logic                                S_AXIS_TVALID,
  output logic                                S_AXIS_TREADY,
  input  logic                                S_AXIS_TLAST,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
  output logic                                M_AXIS_TVALID,
  input  logic                                M_AXIS_TREADY,
  output logic                                M_AXIS_TLAST,
  input  logic [NUM_PORTS*48-1:0]             mac_table,
  input  logic                                filter_en,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       counter_clr,
  output logic [NUM_PORTS*32-1:0]             pass_count,
  output logic [NUM_PORTS*32-1:0]             drop_count,
  output logic [31:0]                         bad_src_count,
  output logic [1:0]                          fsm_state
);

  localparam int DW    = C_S_AXIS_DATA_WIDTH;
  localparam int SW    = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW    = C_S_AXIS_TUSER_WIDTH;
  localparam int EW    = DW + SW + UW + 1;
  localparam int DEPTH = 2 ** FIFO_DEPTH_BITS;
  localparam logic [FIFO_DEPTH_BITS:0] NF_LVL = (FIFO_DEPTH_BITS + 1)'(DEPTH - 1);
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PASS = 2'd1, ST_DROP = 2'd2} state_t;

  state_t                      state_q, state_d;
  logic [EW-1:0]               fifo_mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_BITS:0]    count_q, count_d;
  logic [31:0]                 pass_cnt_q [NUM_PORTS];
  logic [31:0]                 pass_cnt_d [NUM_PORTS];
  logic [31:0]                 drop_cnt_q [NUM_PORTS];
  logic [31:0]                 drop_cnt_d [NUM_PORTS];
  logic [31:0]                 bad_cnt_q, bad_cnt_d;

  logic                        push, pop, empty, hdr_pop, m_valid;
  logic [DW-1:0]               head_data;
  logic [SW-1:0]               head_strb;
  logic [UW-1:0]               head_user;
  logic                        head_last;
  logic [47:0]                 dmac;
  logic [NUM_PORTS-1:0]        src, mac_ok, pass_vec, drop_vec;
  logic                        src_multi, bad_inc, hdr_pass, hdr_fwd, cnt_clr;

  assign empty         = (count_q == '0);
  assign S_AXIS_TREADY = (count_q < NF_LVL);
  assign push          = S_AXIS_TVALID & S_AXIS_TREADY;
  assign {head_last, head_user, head_strb, head_data} = fifo_mem[rd_ptr_q];

  assign M_AXIS_TDATA  = head_data;
  assign M_AXIS_TSTRB  = head_strb;
  assign M_AXIS_TUSER  = head_user;
  assign M_AXIS_TLAST  = head_last;
  assign M_AXIS_TVALID = m_valid;
  assign fsm_state     = state_q;
  assign cnt_clr       = (counter_clr == C_S_AXI_DATA_WIDTH'(1));

  // FIFO storage; contents need no reset because occupancy is tracked by count_q.
  always_ff @(posedge AXI_ACLK) begin
    if (push) fifo_mem[wr_ptr_q] <= {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q + FIFO_DEPTH_BITS'(push);
    rd_ptr_d = rd_ptr_q + FIFO_DEPTH_BITS'(pop);
    count_d  = count_q + (FIFO_DEPTH_BITS + 1)'(push) - (FIFO_DEPTH_BITS + 1)'(pop);
  end

  // Classify the head beat as a header: source port decode and MAC match.
  always_comb begin
    dmac      = head_data[DW-1 -: 48];
    src       = '0;
    mac_ok    = '0;
    pass_vec  = '0;
    drop_vec  = '0;
    bad_inc   = 1'b0;
    hdr_pass  = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      src[i]    = head_user[SRC_PORT_POS + 2*i];
      mac_ok[i] = (dmac == mac_table[48*i +: 48]) || (dmac == {48{1'b1}}) ||
                  ((MCAST_EN != 0) && dmac[40]);
    end
    src_multi = ($countones(src) > 1);
    if (!filter_en) begin
      // Bypass: everything passes; a single-port source still counts as a pass.
      if (!src_multi) pass_vec = src;
    end else if (src_multi) begin
      hdr_pass = 1'b0;
      bad_inc  = 1'b1;
    end else if (src != '0) begin
      if ((src & mac_ok) != '0) pass_vec = src;
      else begin
        hdr_pass = 1'b0;
        drop_vec = src;
      end
    end
    hdr_fwd = hdr_pass || (DROP_EN == 0);
  end

  // Packet FSM: decision is taken when the header pops and holds to TLAST.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    m_valid = 1'b0;
    hdr_pop = 1'b0;
    case (state_q)
      ST_IDLE: if (!empty) begin
        m_valid = hdr_fwd;
        pop     = hdr_fwd ? M_AXIS_TREADY : 1'b1;
        hdr_pop = pop;
        if (pop && !head_last) state_d = hdr_fwd ? ST_PASS : ST_DROP;
      end
      ST_PASS: begin
        m_valid = !empty;
        pop     = !empty && M_AXIS_TREADY;
        if (pop && head_last) state_d = ST_IDLE;
      end
      ST_DROP: begin
        pop = !empty;
        if (pop && head_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating counters; a clear overrides any increment in the same cycle.
  always_comb begin
    bad_cnt_d = bad_cnt_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pass_cnt_d[i] = pass_cnt_q[i];
      drop_cnt_d[i] = drop_cnt_q[i];
    end
    if (cnt_clr) begin
      bad_cnt_d = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        pass_cnt_d[i] = '0;
        drop_cnt_d[i] = '0;
      end
    end else if (hdr_pop) begin
      if (bad_inc && bad_cnt_q != CNT_MAX) bad_cnt_d = bad_cnt_q + 32'd1;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (pass_vec[i] && pass_cnt_q[i] != CNT_MAX) pass_cnt_d[i] = pass_cnt_q[i] + 32'd1;
        if (drop_vec[i] && drop_cnt_q[i] != CNT_MAX) drop_cnt_d[i] = drop_cnt_q[i] + 32'd1;
      end
    end
  end

  // State, FIFO pointers and counters with asynchronous reset.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      bad_cnt_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        pass_cnt_q[i] <= '0;
        drop_cnt_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      bad_cnt_q <= bad_cnt_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        pass_cnt_q[i] <= pass_cnt_d[i];
        drop_cnt_q[i] <= drop_cnt_d[i];
      end
    end
  end

  assign bad_src_count = bad_cnt_q;
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt_out
    assign pass_count[32*g +: 32] = pass_cnt_q[g];
    assign drop_count[32*g +: 32] = drop_cnt_q[g];
  end

endmodule
